// File: rtl/sdio_dev_cmd_if.sv
// Controller-side bundle of the SD card command endpoint:
// decoded command out, response request in.
interface sdio_dev_cmd_if;
  logic         cmd_valid_o;
  logic [5:0]   cmd_op_o;
  logic [31:0]  cmd_arg_o;
  logic         cmd_crc_err_o;
  logic         cmd_end_err_o;
  logic         busy_o;
  logic         rsp_start_i;
  logic [1:0]   rsp_type_i;
  logic [31:0]  rsp_arg_i;
  logic [127:0] rsp_data_i;

  modport slave (
    output cmd_valid_o, cmd_op_o, cmd_arg_o,
    output cmd_crc_err_o, cmd_end_err_o, busy_o,
    input  rsp_start_i, rsp_type_i, rsp_arg_i, rsp_data_i
  );

  modport master (
    input  cmd_valid_o, cmd_op_o, cmd_arg_o,
    input  cmd_crc_err_o, cmd_end_err_o, busy_o,
    output rsp_start_i, rsp_type_i, rsp_arg_i, rsp_data_i
  );
endinterface

// File: rtl/sdio_dev_cmd.sv
// SD card-side CMD line endpoint: receives 48-bit host
// commands, checks CRC7/end bit, serializes R1/R2/R3 replies.
module sdio_dev_cmd #(
  parameter int unsigned NCR_MIN = 2
) (
  input  logic          clk_i,
  input  logic          rstn_i,
  input  logic          sdcmd_i,
  output logic          sdcmd_o,
  output logic          sdcmd_oen_o,
  sdio_dev_cmd_if.slave ctl
);
  typedef enum logic [2:0] {
    ST_IDLE, ST_RX, ST_WAIT_RSP, ST_NCR, ST_TX
  } state_e;

  localparam logic [5:0] NcrMin = 6'(NCR_MIN);

  state_e       st_q, st_d;
  logic [7:0]   cnt_q, cnt_d;
  logic [45:0]  sh_q, sh_d;
  logic [6:0]   crc_q, crc_d;
  logic [5:0]   ncr_q, ncr_d;
  logic [1:0]   typ_q, typ_d;
  logic [31:0]  arg_q, arg_d;
  logic [119:0] dat_q, dat_d;
  logic [134:0] tx_q, tx_d;
  logic         out_q, out_d;
  logic         oen_q, oen_d;
  logic         vld_q, vld_d;
  logic         crce_q, crce_d;
  logic         ende_q, ende_d;
  logic [5:0]   op_q, op_d;
  logic [31:0]  carg_q, carg_d;
  logic         go_tx;
  logic         ncr_ok;
  logic         unused_lsb;

  assign unused_lsb = ^ctl.rsp_data_i[7:0];
  assign ncr_ok = (ncr_q >= NcrMin);

  function automatic logic [6:0] crc_step(
    logic [6:0] c, logic b);
    logic fb;
    fb = b ^ c[6];
    return {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
  endfunction

  // Frame after the start bit; CRC slots are filled in flight.
  function automatic logic [134:0] frame(
    logic [1:0] t, logic [5:0] op,
    logic [31:0] a, logic [119:0] d);
    logic [134:0] f;
    case (t)
      2'd2:    f = {1'b0, 6'h3f, d, 7'h00, 1'b1};
      2'd3:    f = {1'b0, 6'h3f, a, 7'h7f, 1'b1, 88'd0};
      default: f = {1'b0, op, a, 7'h00, 1'b1, 88'd0};
    endcase
    return f;
  endfunction

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    sh_d   = sh_q;
    crc_d  = crc_q;
    typ_d  = typ_q;
    arg_d  = arg_q;
    dat_d  = dat_q;
    tx_d   = tx_q;
    out_d  = 1'b1;
    oen_d  = 1'b1;
    vld_d  = 1'b0;
    crce_d = crce_q;
    ende_d = ende_q;
    op_d   = op_q;
    carg_d = carg_q;
    go_tx  = 1'b0;
    ncr_d  = (ncr_q == 6'd63) ? ncr_q : ncr_q + 6'd1;
    case (st_q)
      ST_IDLE: begin
        if (!sdcmd_i) begin
          st_d  = ST_RX;
          cnt_d = 8'd46;
          crc_d = '0;
        end
      end
      ST_RX: begin
        sh_d  = {sh_q[44:0], sdcmd_i};
        cnt_d = cnt_q - 8'd1;
        if (cnt_q >= 8'd8) crc_d = crc_step(crc_q, sdcmd_i);
        if (cnt_q == 8'd0) begin
          ncr_d = '0;
          st_d  = ST_IDLE;
          if (sh_q[45]) begin
            vld_d  = 1'b1;
            op_d   = sh_q[44:39];
            carg_d = sh_q[38:7];
            crce_d = (crc_q != sh_q[6:0]);
            ende_d = !sdcmd_i;
            if (crc_q == sh_q[6:0] && sdcmd_i)
              st_d = ST_WAIT_RSP;
          end
        end
      end
      ST_WAIT_RSP: begin
        // A new host start bit beats a same-cycle response request.
        if (!sdcmd_i) begin
          st_d  = ST_RX;
          cnt_d = 8'd46;
          crc_d = '0;
        end else if (ctl.rsp_start_i) begin
          typ_d = ctl.rsp_type_i;
          arg_d = ctl.rsp_arg_i;
          dat_d = ctl.rsp_data_i[127:8];
          if (ctl.rsp_type_i == 2'd0) st_d = ST_IDLE;
          else if (ncr_ok) go_tx = 1'b1;
          else st_d = ST_NCR;
        end
      end
      ST_NCR: begin
        if (ncr_ok) go_tx = 1'b1;
      end
      ST_TX: begin
        ncr_d = ncr_q;
        if (cnt_q == 8'd0) begin
          st_d = ST_IDLE;
        end else begin
          oen_d = 1'b0;
          cnt_d = cnt_q - 8'd1;
          tx_d  = {tx_q[133:0], 1'b0};
          if (typ_q != 2'd3 && cnt_q >= 8'd2 &&
              cnt_q <= 8'd8) begin
            out_d = crc_q[6];
            crc_d = {crc_q[5:0], 1'b0};
          end else begin
            out_d = tx_q[134];
            if (typ_q != 2'd3 && cnt_q >= 8'd9 &&
                cnt_q <= 8'd128)
              crc_d = crc_step(crc_q, tx_q[134]);
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
    // Start bit goes out on the edge that enters ST_TX.
    if (go_tx) begin
      st_d  = ST_TX;
      out_d = 1'b0;
      oen_d = 1'b0;
      crc_d = '0;
      ncr_d = ncr_q;
      tx_d  = frame(typ_d, op_q, arg_d, dat_d);
      cnt_d = (typ_d == 2'd2) ? 8'd135 : 8'd47;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      sh_q   <= '0;
      crc_q  <= '0;
      ncr_q  <= '0;
      typ_q  <= '0;
      arg_q  <= '0;
      dat_q  <= '0;
      tx_q   <= '0;
      out_q  <= 1'b1;
      oen_q  <= 1'b1;
      vld_q  <= 1'b0;
      crce_q <= 1'b0;
      ende_q <= 1'b0;
      op_q   <= '0;
      carg_q <= '0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      sh_q   <= sh_d;
      crc_q  <= crc_d;
      ncr_q  <= ncr_d;
      typ_q  <= typ_d;
      arg_q  <= arg_d;
      dat_q  <= dat_d;
      tx_q   <= tx_d;
      out_q  <= out_d;
      oen_q  <= oen_d;
      vld_q  <= vld_d;
      crce_q <= crce_d;
      ende_q <= ende_d;
      op_q   <= op_d;
      carg_q <= carg_d;
    end
  end

  assign sdcmd_o           = out_q;
  assign sdcmd_oen_o       = oen_q;
  assign ctl.cmd_valid_o   = vld_q;
  assign ctl.cmd_op_o      = op_q;
  assign ctl.cmd_arg_o     = carg_q;
  assign ctl.cmd_crc_err_o = crce_q;
  assign ctl.cmd_end_err_o = ende_q;
  assign ctl.busy_o        = (st_q != ST_IDLE);
endmodule
